// File: rtl/muldiv_pkg.sv
// Shared constants and the FSM state type for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int RD_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned core: operand magnitudes at acceptance,
// and the final negation plus word/quotient/remainder select in FIX.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        i_acc_f3,
  input  logic [XLEN-1:0]   i_rs1,
  input  logic [XLEN-1:0]   i_rs2,
  output logic              o_a_neg,
  output logic              o_b_neg,
  output logic [XLEN-1:0]   o_a_mag,
  output logic [XLEN-1:0]   o_b_mag,
  input  logic [2:0]        i_f3,
  input  logic              i_a_neg,
  input  logic              i_b_neg,
  input  logic [2*XLEN-1:0] i_prod,
  input  logic [XLEN-1:0]   i_quot,
  input  logic [XLEN-1:0]   i_rem,
  output logic [XLEN-1:0]   o_result
);

  logic              w_signed_a;
  logic              w_signed_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;

  always_comb begin
    w_signed_a = (i_acc_f3 == F3_MULH) || (i_acc_f3 == F3_MULHSU) ||
                 (i_acc_f3 == F3_DIV)  || (i_acc_f3 == F3_REM);
    w_signed_b = (i_acc_f3 == F3_MULH) || (i_acc_f3 == F3_DIV) ||
                 (i_acc_f3 == F3_REM);
    o_a_neg    = w_signed_a && i_rs1[XLEN-1];
    o_b_neg    = w_signed_b && i_rs2[XLEN-1];
    // INT_MIN negates to itself, which is exactly its unsigned magnitude.
    o_a_mag    = o_a_neg ? -i_rs1 : i_rs1;
    o_b_mag    = o_b_neg ? -i_rs2 : i_rs2;
  end

  always_comb begin
    w_prod   = (i_a_neg ^ i_b_neg) ? -i_prod : i_prod;
    w_quot   = (i_a_neg ^ i_b_neg) ? -i_quot : i_quot;
    w_rem    = i_a_neg ? -i_rem : i_rem;
    o_result = '0;
    case (i_f3)
      F3_MUL:                         o_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   o_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                o_result = w_quot;
      default:                        o_result = w_rem;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps, then one sign-fix cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RD_W-1:0] rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out
);

  // Handshake: start is taken on a rising edge only when busy=0 and kill=0;
  // done is a single-cycle valid for result/rd_out, which then hold until the next done.

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_f3;
  logic [RD_W-1:0]     r_rd_tag;
  logic                r_a_neg;
  logic                r_b_neg;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quot;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done;
  logic [XLEN-1:0]     r_result;
  logic [RD_W-1:0]     r_rd;

  logic                w_accept;
  logic                w_is_div;
  logic                w_b_zero;
  logic                w_ovf;
  logic                w_special;
  logic                w_cnt_last;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_div_shift;
  logic [XLEN:0]       w_div_trial;
  logic [XLEN-1:0]     w_fix_result;

  assign w_accept   = (r_state == S_IDLE) && start && !kill;
  assign w_is_div   = funct3[2];
  assign w_b_zero   = (rs2_data == '0);
  assign w_ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);
  assign w_special  = w_is_div && (w_b_zero || w_ovf);
  assign w_cnt_last = (r_cnt == CNT_W'(XLEN-1));

  // Product accumulates in the upper half while the multiplier shifts out of the lower half.
  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_div_shift = {r_rem, r_quot[XLEN-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};

  muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .i_acc_f3 (funct3),
    .i_rs1    (rs1_data),
    .i_rs2    (rs2_data),
    .o_a_neg  (w_a_neg),
    .o_b_neg  (w_b_neg),
    .o_a_mag  (w_a_mag),
    .o_b_mag  (w_b_mag),
    .i_f3     (r_f3),
    .i_a_neg  (r_a_neg),
    .i_b_neg  (r_b_neg),
    .i_prod   (r_acc),
    .i_quot   (r_quot),
    .i_rem    (r_rem),
    .o_result (w_fix_result)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_FIX : (w_is_div ? S_DIV : S_MUL);
      S_MUL:  if (w_cnt_last) w_next = S_FIX;
      S_DIV:  if (w_cnt_last) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (kill && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f3     <= '0;
      r_rd_tag <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3     <= funct3;
            r_rd_tag <= rd_in;
            r_cnt    <= '0;
            r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
            r_acc    <= {{XLEN{1'b0}}, w_b_mag};
            if (w_special) begin
              // Final values are loaded unsigned so FIX passes them through untouched.
              r_a_neg <= 1'b0;
              r_b_neg <= 1'b0;
              r_quot  <= w_b_zero ? ALL_ONES : INT_MIN;
              r_rem   <= w_b_zero ? rs1_data : '0;
            end else begin
              r_a_neg <= w_a_neg;
              r_b_neg <= w_b_neg;
              r_quot  <= w_a_mag;
              r_rem   <= '0;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DIV: begin
          if (!w_div_trial[XLEN]) begin
            r_rem  <= w_div_trial[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], 1'b1};
          end else begin
            r_rem  <= w_div_shift[XLEN-1:0];
            r_quot <= {r_quot[XLEN-2:0], 1'b0};
          end
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (!kill) begin
            r_result <= w_fix_result;
            r_rd     <= r_rd_tag;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic vectors, special cases, latency, start/kill/reset behaviour.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks;
  int failures;

  muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kill     (kill),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: call #1 after a rising edge with the unit idle. Returns cycles from accept
  // to done (-1 on timeout) and whether busy stayed high until done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic busy_ok);
    funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = '0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd: got %0d expected 0", rd_out); end
    #21 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [2:0]  f3 [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
    logic [31:0] a  [4] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat;
    logic bok;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], 5'(i + 5), lat, bok);
      checks++; if (lat != 33) begin failures++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, lat); end
      checks++; if (result !== ex[i]) begin failures++; $display("FAIL mul_result[%0d]: got %h expected %h", i, result, ex[i]); end
      checks++; if (rd_out !== 5'(i + 5)) begin failures++; $display("FAIL mul_rd[%0d]: got %0d expected %0d", i, rd_out, i + 5); end
      checks++; if (!bok || busy !== 1'b0) begin failures++; $display("FAIL mul_busy[%0d]: held=%b at_done=%b expected 1/0", i, bok, busy); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] a  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    int lat;
    logic bok;
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], 5'(i + 20), lat, bok);
      checks++; if (lat != 33) begin failures++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
      checks++; if (result !== ex[i]) begin failures++; $display("FAIL div_result[%0d]: got %h expected %h", i, result, ex[i]); end
      checks++; if (rd_out !== 5'(i + 20)) begin failures++; $display("FAIL div_rd[%0d]: got %0d expected %0d", i, rd_out, i + 20); end
    end
  endtask

  task automatic test_special;
    logic [2:0]  f3 [5] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b111};
    logic [31:0] a  [5] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [31:0] b  [5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] ex [5] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFF0};
    int lat;
    logic bok;
    for (int i = 0; i < 5; i++) begin
      run_op(f3[i], a[i], b[i], 5'(i + 1), lat, bok);
      checks++; if (lat != 1) begin failures++; $display("FAIL special_latency[%0d]: got %0d expected 1", i, lat); end
      checks++; if (result !== ex[i]) begin failures++; $display("FAIL special_result[%0d]: got %h expected %h", i, result, ex[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ignore_done: got %b expected 1", done); end
    checks++; if (result !== 32'd14) begin failures++; $display("FAIL ignore_result: got %h expected %h", result, 32'd14); end
    checks++; if (rd_out !== 5'd3) begin failures++; $display("FAIL ignore_rd: got %0d expected 3", rd_out); end
    // Issue the next request in the very cycle done is high.
    funct3 = 3'b011; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF; rd_in = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_accept: busy=%b done=%b expected 1/0", busy, done); end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 33) begin failures++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    checks++; if (result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL b2b_result: got %h expected %h", result, 32'hFFFF_FFFE); end
    checks++; if (rd_out !== 5'd12) begin failures++; $display("FAIL b2b_rd: got %0d expected 12", rd_out); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_kill;
    int lat;
    logic bok;
    logic seen;
    run_op(3'b111, 32'd100, 32'd7, 5'd2, lat, bok);
    funct3 = 3'b100; rs1_data = 32'hFFFF_FFF9; rs2_data = 32'd2; rd_in = 5'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kill_busy: got %b expected 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL kill_no_done: got %b expected 0", seen); end
    checks++; if (result !== 32'd2) begin failures++; $display("FAIL kill_result: got %h expected %h", result, 32'd2); end
    checks++; if (rd_out !== 5'd2) begin failures++; $display("FAIL kill_rd: got %0d expected 2", rd_out); end
    // kill together with start in IDLE must not accept.
    funct3 = 3'b000; rs1_data = 32'd2; rs2_data = 32'd2; rd_in = 5'd1; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL kill_start_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd17; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL rstmid_result: got %h expected 0", result); end
    checks++; if (rd_out !== 5'd0) begin failures++; $display("FAIL rstmid_rd: got %0d expected 0", rd_out); end
    #10 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_resume: got %b expected 0", seen); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage, downstream of the ID-stage register file.
- Consumes the two register read operands plus funct3 and the destination register tag.
- Produces a 32-bit result and the tag for write-back into the register file.
- Holds the pipeline stalled through busy while an operation is in flight.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  request; accepted only when busy=0 and kill=0
kill  input  1  pipeline flush; aborts any in-flight op
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  32  operand A (dividend / multiplicand)
rs2_data  input  32  operand B (divisor / multiplier)
rd_in  input  5  destination register tag
busy  output  1  op in flight; stall request to pipeline
done  output  1  one-cycle pulse: result/rd_out valid
result  output  32  registered result
rd_out  output  5  tag accompanying result (register-file waddr)

Behaviour:
- All state is updated on posedge clk. When rst=0, asynchronously: state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0.
- States: IDLE, MUL, DIV, FIX.
- Accept at edge E0 if state=IDLE, start=1, kill=0:
  - Latch funct3 and rd_in.
  - Latch operand signs: signed ops are MULH, DIV, REM for both operands; MULHSU for A only.
  - Latch magnitudes |A| and |B| as 32-bit unsigned values.
  - busy=1 from E0.
- Special cases resolved at acceptance; next state is FIX with the final value preloaded, no iterations:
  - B=0, DIV/DIVU: quotient 0xFFFFFFFF.
  - B=0, REM/REMU: remainder = A.
  - DIV/REM with A=0x80000000 and B=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- MUL state: radix-2 shift-add over 64-bit accumulator, one bit per cycle, edges E1..E32; counter 0..31, leave at 31.
- DIV state: restoring division, 33-bit partial remainder, one quotient bit per cycle, edges E1..E32.
- FIX state, one edge:
  - Negate the product if operand signs differ.
  - Negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Select low 32 bits (MUL) or high 32 bits (MULH*); quotient or remainder.
  - Register result and rd_out, done=1, busy=0, return to IDLE.
- Latency: normal op done at E33, i.e. 33 cycles after accept; special case done at E1.
- done is high exactly one cycle. result and rd_out hold until the next done or reset.
- start while busy=1 is ignored: no queuing, and operands are not resampled.
- Back-to-back: start may be accepted in the cycle where done=1 (state is IDLE then).
- kill=1 at any edge with state≠IDLE: go to IDLE, busy=0, no done; result and rd_out unchanged.
- kill=1 with start=1 in IDLE: not accepted.
- Reset mid-operation aborts immediately; no done.
- Width rules: all magnitude arithmetic is unsigned. Negation is two's complement modulo 2^XLEN (64 bits for the product). |0x80000000| = 0x80000000 unsigned.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams (F3_MUL ... F3_REMU).
  - State encodings S_IDLE/S_MUL/S_DIV/S_FIX (2 bits).
  - Helper constants INT_MIN=0x80000000, ALL_ONES=0xFFFFFFFF.
- One natural sub-module: muldiv_sign_fix.
  - Combinational.
  - Computes magnitudes at acceptance and applies the final negation and word select in FIX.
- FSM and iteration datapath stay in muldiv_unit.

Test Plan:
- MUL 7 × 0xFFFFFFFD, rd_in=5 -> done exactly 33 cycles after accept; result=0xFFFFFFEB; rd_out=5; busy high for those 33 cycles.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; each done 1 cycle after accept.
- start pulsed during busy with different operands -> ignored, original result returned; start in the done cycle -> accepted, second result correct.
- kill on 10th iteration -> busy=0 next edge, no done, result unchanged. rst=0 mid-DIV -> busy, done, result, rd_out all 0 immediately, without waiting for a clock edge.
